// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the parametrised TAP controller.
// Holds the TAP state codes, instruction opcodes and Capture-IR pattern.
package jtag_pkg;

   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PAU_DR = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PAU_IR = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } tap_state_e;

   typedef enum logic [2:0] {
      I_BYPASS,
      I_SAMPLE,
      I_EXTEST,
      I_INTEST,
      I_CLAMP,
      I_IDCODE,
      I_USERCODE,
      I_HIGHZ
   } instr_e;

   localparam logic [31:0] OP_SAMPLE   = 32'd1;
   localparam logic [31:0] OP_EXTEST   = 32'd2;
   localparam logic [31:0] OP_INTEST   = 32'd3;
   localparam logic [31:0] OP_CLAMP    = 32'd5;
   localparam logic [31:0] OP_IDCODE   = 32'd7;
   localparam logic [31:0] OP_USERCODE = 32'd8;
   localparam logic [31:0] OP_HIGHZ    = 32'd9;

   // Low bits loaded into the IR shifter at Capture-IR; upper bits are 0.
   localparam logic [1:0] CAPIR_PAT = 2'b01;

   // Map a zero-extended IR value onto an instruction; unknown -> BYPASS.
   function automatic instr_e decode_ir(input logic [31:0] op,
                                        input logic        all_ones,
                                        input logic        uc_en);
      instr_e r;
      r = I_BYPASS;
      if (!all_ones) begin
         case (op)
            OP_SAMPLE:   r = I_SAMPLE;
            OP_EXTEST:   r = I_EXTEST;
            OP_INTEST:   r = I_INTEST;
            OP_CLAMP:    r = I_CLAMP;
            OP_IDCODE:   r = I_IDCODE;
            OP_USERCODE: r = uc_en ? I_USERCODE : I_BYPASS;
            OP_HIGHZ:    r = I_HIGHZ;
            default:     r = I_BYPASS;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state IEEE 1149.1 TMS state machine.
// Exposes the raw state code plus one-hot decodes of the action states.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tms_i,
   output logic [3:0] state_o,
   output logic       tlr_o,
   output logic       cap_dr_o,
   output logic       sh_dr_o,
   output logic       upd_dr_o,
   output logic       cap_ir_o,
   output logic       sh_ir_o,
   output logic       upd_ir_o
);

   tap_state_e state_q, state_d;

   // State register; reset forces Test-Logic-Reset regardless of TMS.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= TLR;
      else       state_q <= state_d;
   end

   // Standard TAP transitions driven by TMS.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = tms_i ? TLR    : RTI;
         RTI:    state_d = tms_i ? SEL_DR : RTI;
         SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
         PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
         EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms_i ? SEL_DR : RTI;
         SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
         CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
         PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
         EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms_i ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   assign state_o  = state_q;
   assign tlr_o    = (state_q == TLR);
   assign cap_dr_o = (state_q == CAP_DR);
   assign sh_dr_o  = (state_q == SH_DR);
   assign upd_dr_o = (state_q == UPD_DR);
   assign cap_ir_o = (state_q == CAP_IR);
   assign sh_ir_o  = (state_q == SH_IR);
   assign upd_ir_o = (state_q == UPD_IR);

endmodule

// File: rtl/jtag_tap_ctrl_p.sv
// jtag_tap_ctrl_p: parametrised TAP with IR, DR muxing, BSR and TDO logic.
// Define JTAG_USERCODE_EN to include the USERCODE instruction and register.
module jtag_tap_ctrl_p
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH     = 4,
   parameter int          BSR_LEN      = 8,
   parameter logic [31:0] IDCODE_VAL   = 32'h1234_5093,
   parameter logic [31:0] USERCODE_VAL = 32'h0000_0000
) (
   input  logic               TCK,
   input  logic               RST,
   input  logic               TMS,
   input  logic               TDI,
   output logic               TDO,
   output logic               TDO_EN,
   input  logic [BSR_LEN-1:0] CORE_DO,
   input  logic [BSR_LEN-1:0] PAD_DI,
   output logic [BSR_LEN-1:0] PAD_DO,
   output logic               PAD_OE,
   output logic [3:0]         STATE
);

   localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(CAPIR_PAT);
   localparam logic [IR_WIDTH-1:0] IR_RST = IR_WIDTH'(OP_IDCODE);

   logic tlr, cap_dr, sh_dr, upd_dr;
   logic cap_ir, sh_ir, upd_ir;

   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [IR_WIDTH-1:0] irsr_q, irsr_d;
   logic                byp_q, byp_d;
   logic [31:0]         id_q, id_d;
   logic [BSR_LEN-1:0]  bsr_q, bsr_d;
   logic [BSR_LEN-1:0]  upd_q, upd_d;
   logic [BSR_LEN:0]    bsr_ext;
   logic                tdo_d, tdo_q;
   logic                en_d, en_q;
   logic                uc_lsb;
   instr_e              instr;
   logic                sel_bsr, sel_id, sel_byp;

   jtag_tap_fsm u_fsm (
      .clk_i    (TCK),
      .rst_i    (RST),
      .tms_i    (TMS),
      .state_o  (STATE),
      .tlr_o    (tlr),
      .cap_dr_o (cap_dr),
      .sh_dr_o  (sh_dr),
      .upd_dr_o (upd_dr),
      .cap_ir_o (cap_ir),
      .sh_ir_o  (sh_ir),
      .upd_ir_o (upd_ir)
   );

`ifdef JTAG_USERCODE_EN
   localparam logic UC_EN = 1'b1;
   logic [31:0] uc_q, uc_d;
   logic        sel_uc;

   assign sel_uc = (instr == I_USERCODE);

   // USERCODE register next state: capture constant, right shift.
   always_comb begin
      uc_d = uc_q;
      if (cap_dr && sel_uc)     uc_d = USERCODE_VAL;
      else if (sh_dr && sel_uc) uc_d = {TDI, uc_q[31:1]};
   end

   // USERCODE register state.
   always_ff @(posedge TCK) begin
      if (RST) uc_q <= USERCODE_VAL;
      else     uc_q <= uc_d;
   end

   assign uc_lsb = uc_q[0];
`else
   localparam logic UC_EN = 1'b0;
   assign uc_lsb = 1'b0;
`endif

   assign instr   = decode_ir(32'(ir_q), &ir_q, UC_EN);
   assign sel_bsr = (instr == I_SAMPLE) || (instr == I_EXTEST) ||
                    (instr == I_INTEST);
   assign sel_id  = (instr == I_IDCODE);
   assign sel_byp = (instr == I_BYPASS) || (instr == I_CLAMP) ||
                    (instr == I_HIGHZ);
   assign bsr_ext = {TDI, bsr_q};

   // IR shifter capture/shift and IR update; TLR forces IDCODE.
   always_comb begin
      irsr_d = irsr_q;
      ir_d   = ir_q;
      if (cap_ir)     irsr_d = IR_CAP;
      else if (sh_ir) irsr_d = {TDI, irsr_q[IR_WIDTH-1:1]};
      if (upd_ir)     ir_d = irsr_q;
      if (tlr)        ir_d = IR_RST;
   end

   // IR state.
   always_ff @(posedge TCK) begin
      if (RST) begin
         ir_q   <= IR_RST;
         irsr_q <= IR_CAP;
      end else begin
         ir_q   <= ir_d;
         irsr_q <= irsr_d;
      end
   end

   // DR next state: only the selected register captures or shifts.
   always_comb begin
      byp_d = byp_q;
      id_d  = id_q;
      bsr_d = bsr_q;
      upd_d = upd_q;
      if (cap_dr) begin
         if (sel_byp) byp_d = 1'b0;
         if (sel_id)  id_d  = IDCODE_VAL;
         if (sel_bsr) bsr_d = (instr == I_INTEST) ? CORE_DO : PAD_DI;
      end else if (sh_dr) begin
         if (sel_byp) byp_d = TDI;
         if (sel_id)  id_d  = {TDI, id_q[31:1]};
         if (sel_bsr) bsr_d = bsr_ext[BSR_LEN:1];
      end
      if (upd_dr && sel_bsr) upd_d = bsr_q;
      if (tlr)               upd_d = '0;
   end

   // DR state; a reset discards any partial shift.
   always_ff @(posedge TCK) begin
      if (RST) begin
         byp_q <= 1'b0;
         id_q  <= IDCODE_VAL;
         bsr_q <= '0;
         upd_q <= '0;
      end else begin
         byp_q <= byp_d;
         id_q  <= id_d;
         bsr_q <= bsr_d;
         upd_q <= upd_d;
      end
   end

   // TDO source: LSB of the active shifter, 0 outside shift states.
   always_comb begin
      tdo_d = 1'b0;
      en_d  = sh_ir | sh_dr;
      if (sh_ir) begin
         tdo_d = irsr_q[0];
      end else if (sh_dr) begin
         case (instr)
            I_SAMPLE,
            I_EXTEST,
            I_INTEST:   tdo_d = bsr_q[0];
            I_IDCODE:   tdo_d = id_q[0];
            I_USERCODE: tdo_d = uc_lsb;
            default:    tdo_d = byp_q;
         endcase
      end
   end

   // TDO and its enable change on the falling edge only.
   always_ff @(negedge TCK) begin
      tdo_q <= tdo_d;
      en_q  <= en_d;
   end

   assign TDO    = tdo_q;
   assign TDO_EN = en_q;
   assign PAD_DO = ((instr == I_EXTEST) || (instr == I_CLAMP)) ?
                   upd_q : CORE_DO;
   assign PAD_OE = (instr != I_HIGHZ);

endmodule

// File: tb/tb_jtag_tap_ctrl_p.sv
// tb_jtag_tap_ctrl_p: directed table and sequence checks for the TAP.
// Outputs are sampled 1ns after each falling TCK edge.
module tb_jtag_tap_ctrl_p;

   logic       TCK = 1'b0;
   logic       RST, TMS, TDI;
   logic       TDO, TDO_EN, PAD_OE;
   logic [7:0] CORE_DO, PAD_DI, PAD_DO;
   logic [3:0] STATE;

   int   n_pass = 0;
   int   n_tot  = 0;
   logic dmy;
   logic [63:0] d;

   typedef struct {
      logic       tms;
      logic [3:0] st;
      logic       en;
   } vec_t;

   vec_t tbl [0:25];

   jtag_tap_ctrl_p dut (
      .TCK     (TCK),
      .RST     (RST),
      .TMS     (TMS),
      .TDI     (TDI),
      .TDO     (TDO),
      .TDO_EN  (TDO_EN),
      .CORE_DO (CORE_DO),
      .PAD_DI  (PAD_DI),
      .PAD_DO  (PAD_DO),
      .PAD_OE  (PAD_OE),
      .STATE   (STATE)
   );

   always #5 TCK = ~TCK;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // One rising edge then the following falling edge; returns TDO.
   task automatic tick(input logic tms, input logic tdi,
                       output logic o);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
      o = TDO;
   endtask

   // From RTI: scan n bits of din LSB-first, finishing in the Update state.
   task automatic scan(input bit ir, input int n,
                       input logic [63:0] din,
                       output logic [63:0] dout);
      logic o;
      dout = '0;
      tick(1'b1, 1'b0, o);
      if (ir) tick(1'b1, 1'b0, o);
      tick(1'b0, 1'b0, o);
      tick(1'b0, 1'b0, o);
      dout[0] = o;
      for (int i = 0; i < n; i++) begin
         tick(i == n - 1, din[i], o);
         if (i < n - 1) dout[i+1] = o;
      end
      tick(1'b1, 1'b0, o);
   endtask

   // Load an instruction from RTI and return to RTI.
   task automatic load_ir(input logic [3:0] op);
      logic [63:0] q;
      logic o;
      scan(1'b1, 4, 64'(op), q);
      chk("capir", q[3:0], 4'b0001);
      tick(1'b0, 1'b0, o);
   endtask

   initial begin
      tbl[0]  = '{1'b0, 4'hC, 1'b0};
      tbl[1]  = '{1'b1, 4'h7, 1'b0};
      tbl[2]  = '{1'b0, 4'h6, 1'b0};
      tbl[3]  = '{1'b0, 4'h2, 1'b1};
      tbl[4]  = '{1'b1, 4'h1, 1'b0};
      tbl[5]  = '{1'b0, 4'h3, 1'b0};
      tbl[6]  = '{1'b1, 4'h0, 1'b0};
      tbl[7]  = '{1'b0, 4'h2, 1'b1};
      tbl[8]  = '{1'b1, 4'h1, 1'b0};
      tbl[9]  = '{1'b1, 4'h5, 1'b0};
      tbl[10] = '{1'b1, 4'h7, 1'b0};
      tbl[11] = '{1'b1, 4'h4, 1'b0};
      tbl[12] = '{1'b0, 4'hE, 1'b0};
      tbl[13] = '{1'b0, 4'hA, 1'b1};
      tbl[14] = '{1'b1, 4'h9, 1'b0};
      tbl[15] = '{1'b0, 4'hB, 1'b0};
      tbl[16] = '{1'b1, 4'h8, 1'b0};
      tbl[17] = '{1'b0, 4'hA, 1'b1};
      tbl[18] = '{1'b1, 4'h9, 1'b0};
      tbl[19] = '{1'b1, 4'hD, 1'b0};
      tbl[20] = '{1'b0, 4'hC, 1'b0};
      tbl[21] = '{1'b1, 4'h7, 1'b0};
      tbl[22] = '{1'b1, 4'h4, 1'b0};
      tbl[23] = '{1'b1, 4'hF, 1'b0};
      tbl[24] = '{1'b1, 4'hF, 1'b0};
      tbl[25] = '{1'b0, 4'hC, 1'b0};

      RST = 1'b1;
      TMS = 1'b0;
      TDI = 1'b0;
      CORE_DO = 8'h3C;
      PAD_DI  = 8'h00;
      tick(1'b0, 1'b0, dmy);
      tick(1'b0, 1'b0, dmy);
      RST = 1'b0;
      chk("rst_state", 64'(STATE), 64'hF);
      chk("rst_tdo_en", 64'(TDO_EN), 64'h0);
      chk("rst_tdo", 64'(TDO), 64'h0);
      chk("rst_pad_oe", 64'(PAD_OE), 64'h1);
      chk("rst_pad_do", 64'(PAD_DO), 64'h3C);

      // Walk every state from TLR.
      for (int i = 0; i < 26; i++) begin
         tick(tbl[i].tms, 1'b0, dmy);
         chk($sformatf("walk%0d", i), 64'({STATE, TDO_EN}),
             64'({tbl[i].st, tbl[i].en}));
      end

      // Five TMS=1 edges reach TLR from wherever random TMS left us.
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(2, 12);
         for (int k = 0; k < n; k++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dmy);
         for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, dmy);
         chk("five_ones", 64'(STATE), 64'hF);
      end
      tick(1'b0, 1'b0, dmy);

      // IDCODE selected after TLR.
      scan(1'b0, 32, 64'h0, d);
      tick(1'b0, 1'b0, dmy);
      chk("idcode", d[31:0], 32'h1234_5093);

      // IR 1111 -> BYPASS; bypass delays TDI by one TCK.
      scan(1'b1, 4, 64'hF, d);
      tick(1'b0, 1'b0, dmy);
      chk("ir_out_1000", d[3:0], 4'b0001);
      scan(1'b0, 8, 64'h81, d);
      tick(1'b0, 1'b0, dmy);
      chk("bypass", d[7:0], 8'h02);

      // SAMPLE captures pads, pads still driven by core.
      PAD_DI = 8'hA5;
      load_ir(4'h1);
      scan(1'b0, 8, 64'h0, d);
      tick(1'b0, 1'b0, dmy);
      chk("sample", d[7:0], 8'hA5);
      chk("sample_pad_do", 64'(PAD_DO), 64'h3C);

      // EXTEST drives the update latch onto the pads.
      CORE_DO = 8'h00;
      load_ir(4'h2);
      scan(1'b0, 8, 64'h6F, d);
      chk("extest_cap", d[7:0], 8'hA5);
      tick(1'b0, 1'b0, dmy);
      chk("extest_pad_do", 64'(PAD_DO), 64'h6F);

      // CLAMP keeps the latch on the pads and selects bypass.
      load_ir(4'h5);
      chk("clamp_pad_do", 64'(PAD_DO), 64'h6F);
      scan(1'b0, 4, 64'hB, d);
      tick(1'b0, 1'b0, dmy);
      chk("clamp_bypass", d[3:0], 4'b0110);
      chk("clamp_pad_do2", 64'(PAD_DO), 64'h6F);

      // HIGHZ takes effect one edge after UpdIR.
      scan(1'b1, 4, 64'h9, d);
      chk("highz_capir", d[3:0], 4'b0001);
      chk("highz_upd_oe", 64'(PAD_OE), 64'h1);
      tick(1'b0, 1'b0, dmy);
      chk("highz_oe", 64'(PAD_OE), 64'h0);
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, dmy);
      chk("highz_tlr", 64'(STATE), 64'hF);
      chk("highz_tlr_oe", 64'(PAD_OE), 64'h1);
      tick(1'b0, 1'b0, dmy);
      scan(1'b0, 32, 64'h0, d);
      tick(1'b0, 1'b0, dmy);
      chk("idcode_after_tlr", d[31:0], 32'h1234_5093);

      // Reset in the middle of a BSR shift.
      load_ir(4'h2);
      scan(1'b0, 8, 64'h6F, d);
      tick(1'b0, 1'b0, dmy);
      chk("pre_rst_pad_do", 64'(PAD_DO), 64'h6F);
      CORE_DO = 8'hFF;
      tick(1'b1, 1'b0, dmy);
      tick(1'b0, 1'b0, dmy);
      tick(1'b0, 1'b0, dmy);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, dmy);
      chk("mid_shift_en", 64'(TDO_EN), 64'h1);
      RST = 1'b1;
      tick(1'b0, 1'b1, dmy);
      RST = 1'b0;
      chk("mid_rst_state", 64'(STATE), 64'hF);
      chk("mid_rst_en", 64'(TDO_EN), 64'h0);
      chk("mid_rst_pad_do", 64'(PAD_DO), 64'hFF);
      tick(1'b0, 1'b0, dmy);
      load_ir(4'h2);
      chk("latch_cleared", 64'(PAD_DO), 64'h00);

      // Opcode 8: 1-bit bypass unless USERCODE is built in.
      load_ir(4'h8);
      scan(1'b0, 8, 64'hCA, d);
      tick(1'b0, 1'b0, dmy);
`ifdef JTAG_USERCODE_EN
      chk("op8", d[7:0], 8'h00);
`else
      chk("op8_bypass", d[7:0], 8'h94);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
